// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and elaboration-time helpers for the streaming 2-D convolver.
//   state_e   : frame-level FSM state encoding (IDLE / RUN / DONE)
//   clog2     : ceiling log2; returns 0 for v <= 1
//   width_of  : clog2 clamped to at least 1, for counters and address ports
//   calc_ow   : full-precision result width for a KxK unsigned dot product
//   COEF_AW   : coefficient address width for the default 3x3 kernel
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (int'(32'd1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int width_of(input int v);
    int r;
    r = clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  // Each product needs DW+CW bits; summing K*K of them adds clog2(K*K) bits.
  function automatic int calc_ow(input int dw, input int cw, input int k);
    return dw + cw + clog2(k * k);
  endfunction

  localparam int K_DEFAULT = 3;
  localparam int COEF_AW   = width_of(K_DEFAULT * K_DEFAULT);

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// Shift-enable delay line of DEPTH pixels. When i_en is high the newest pixel
// enters and every stored pixel moves one place; o_data is the pixel that
// entered DEPTH enables ago (i.e. the same column of the previous image row
// when DEPTH equals the image width).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : shift enable (one per accepted pixel)
//   i_data     : incoming pixel
//   o_data     : pixel delayed by DEPTH enables
// -----------------------------------------------------------------------------
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data
);

  logic [DW-1:0] r_mem [DEPTH];

  // Delay-line storage, advanced only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/conv2d_stream_engine.sv
// -----------------------------------------------------------------------------
// conv2d_stream_engine
// Streaming valid-region KxK convolution over an IMG_W x IMG_H unsigned image.
// Pixels arrive row-major over a valid/ready handshake; each complete window
// produces one full-precision result on a registered valid/ready output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begins a frame (honoured in IDLE only)
//   coef_we/addr/data   : coefficient write port (IDLE only, row-major index)
//   in_valid/ready/data : pixel stream input
//   out_valid/ready/data: result stream output with backpressure
//   busy                : frame in progress (RUN or DONE)
//   frame_done          : one-cycle pulse after the final result is consumed
// -----------------------------------------------------------------------------
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter  int IMG_W = 5,
  parameter  int IMG_H = 5,
  parameter  int K     = 3,
  parameter  int DW    = 2,
  parameter  int CW    = 2,
  parameter  int OW    = calc_ow(DW, CW, K),
  localparam int CAW   = width_of(K * K)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           coef_we,
  input  logic [CAW-1:0] coef_addr,
  input  logic [CW-1:0]  coef_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_data,
  output logic           busy,
  output logic           frame_done
);

  localparam int NT  = K * K;
  localparam int RW  = width_of(IMG_H);
  localparam int CLW = width_of(IMG_W);
  localparam int PW  = DW + CW;

  localparam logic [RW-1:0]  ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CLW-1:0] COL_LAST      = CLW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_FIRST_OUT = RW'(K - 1);
  localparam logic [CLW-1:0] COL_FIRST_OUT = CLW'(K - 1);
  localparam logic [CAW:0]   NT_W          = (CAW + 1)'(NT);

  state_e          r_state;
  state_e          w_state_next;
  logic [RW-1:0]   r_row;
  logic [CLW-1:0]  r_col;
  logic [CW-1:0]   r_coef [NT];
  logic [DW-1:0]   r_win [K][K];
  logic [DW-1:0]   w_win_next [K][K];
  logic [DW-1:0]   w_tap [K];
  logic [OW-1:0]   w_mac;
  logic            r_out_valid;
  logic [OW-1:0]   r_out_data;
  logic            r_frame_done;
  logic            w_in_fire;
  logic            w_last_pix;
  logic            w_win_full;
  logic            w_done_exit;
  logic            w_coef_wr;

  // ---------------------------------------------------------------------------
  // Handshake and status decode
  // ---------------------------------------------------------------------------
  // A new pixel is only taken when the output register is free or draining,
  // so a freshly computed result can never overwrite an unconsumed one.
  assign in_ready    = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_in_fire   = in_valid && in_ready;
  assign w_last_pix  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_done_exit = (r_state == ST_DONE) && (!r_out_valid || out_ready);
  assign w_coef_wr   = coef_we && (r_state == ST_IDLE) && ({1'b0, coef_addr} < NT_W);

  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign frame_done  = r_frame_done;

  // A window is complete once K-1 full rows and K-1 pixels of the current row
  // precede the incoming pixel; this also blocks windows that straddle rows.
  generate
    if (K == 1) begin : g_full_k1
      assign w_win_full = 1'b1;
    end else begin : g_full_kn
      assign w_win_full = (r_row >= ROW_FIRST_OUT) && (r_col >= COL_FIRST_OUT);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Line buffers: w_tap[K-1] is the live pixel, w_tap[0] the oldest row.
  // ---------------------------------------------------------------------------
  assign w_tap[K-1] = in_data;

  generate
    for (genvar m = 0; m < K - 1; m++) begin : g_lb
      conv_line_buffer #(
        .DEPTH (IMG_W),
        .DW    (DW)
      ) u_lb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_in_fire),
        .i_data (w_tap[m+1]),
        .o_data (w_tap[m])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Window and MAC
  // ---------------------------------------------------------------------------
  // Next window: every row shifts left and takes its tap in the right column.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        w_win_next[i][j] = r_win[i][j+1];
      end
      w_win_next[i][K-1] = w_tap[i];
    end
  end

  // Dot product on the post-shift window so the result registers with the
  // pixel that completes it; products are zero-extended before the sum.
  always_comb begin
    logic [PW-1:0] v_prod;
    w_mac  = '0;
    v_prod = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        v_prod = PW'(w_win_next[i][j]) * PW'(r_coef[i*K+j]);
        w_mac  = w_mac + OW'(v_prod);
      end
    end
  end

  // Window register, advanced on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_in_fire) begin
      r_win <= w_win_next;
    end
  end

  // Coefficient bank; writes outside IDLE or beyond K*K are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NT; n++) begin
        r_coef[n] <= '0;
      end
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_in_fire && w_last_pix) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_done_exit) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Row/column position of the next pixel; cleared when a frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_in_fire) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CLW'(1);
      end
    end
  end

  // Output register: load on a completing pixel, otherwise drain on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_fire && w_win_full) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mac;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // End-of-frame pulse, raised together with the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done_exit;
    end
  end

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised streaming successor to the fixed 5x5-image / 3x3-filter 2-bit convolver.
- Accepts one pixel per cycle in row-major order over a valid/ready handshake.
- Holds K-1 line buffers plus a KxK window, and emits each valid-region ("no padding") convolution result over a valid/ready output with backpressure.
- Kernel coefficients are loaded through a register-write port between frames.

Parameters:
- IMG_W, 5, image width in pixels (>= K)
- IMG_H, 5, image height in pixels (>= K)
- K, 3, kernel edge size (odd, >= 1)
- DW, 2, unsigned pixel width
- CW, 2, unsigned coefficient width
- OW, DW+CW+$clog2(K*K), output width (derived; must not be overridden smaller)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a frame (honoured only in IDLE)
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(K*K)  coefficient index, row-major (0 = top-left)
- coef_data  in  CW  coefficient value
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready
- in_data  in  DW  pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  OW  convolution result
- busy  out  1  high in RUN or DONE
- frame_done  out  1  one-cycle pulse when the last result has been consumed

Behaviour:
- Reset (async, rst_n=0): state=IDLE, row/col counters=0, out_valid=0, out_data=0, busy=0, frame_done=0, in_ready=0, all coefficients=0. Line-buffer contents do not matter.
- States:
  - IDLE -> RUN on start.
  - RUN -> DONE on acceptance of pixel IMG_W*IMG_H-1.
  - DONE -> IDLE when out_valid=0, or on the cycle the final result handshakes. frame_done pulses on that transition.
- in_ready = (state==RUN) & (~out_valid | out_ready). It is 0 in IDLE and DONE.
- Per accepted pixel: shift into the window and line buffers; col increments and wraps at IMG_W-1 to 0 with row+1.
- The window is complete when row >= K-1 and col >= K-1 at acceptance.
- Latency: out_valid rises the cycle after accepting a window-completing pixel. out_data = sum over i,j of win[i][j]*coef[i*K+j]. Arithmetic is unsigned, full precision; no truncation at OW.
- Output register:
  - Holds out_data stable while out_valid & ~out_ready.
  - Clears out_valid on handshake unless a new result loads in the same cycle (simultaneous accept + drain is allowed).
- Results per frame: (IMG_W-K+1)*(IMG_H-K+1), in row-major order.
- Row edges: windows never straddle rows; no output for col < K-1.
- Coefficient writes:
  - Take effect in IDLE only. Writes while busy are silently dropped.
  - coef_addr >= K*K is ignored.
- start while busy is ignored.
- Reset mid-frame aborts immediately. No frame_done is issued. The next frame needs a new start; coefficients return to 0.
- K=1 degenerate case: no line buffers, one result per pixel.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - helper functions clog2 and OW derivation
  - a localparam for the coefficient address width
- Sub-module conv_line_buffer (params DEPTH=IMG_W, DW) is a shift-enable delay line, instantiated K-1 times.
- Window register, MAC tree, counters and FSM live in the top.

Test Plan:
- Identity kernel (coef[4]=1, rest 0), 5x5 image rows 11011/00100/11111/01000/11010, out_ready=1 -> 9 results 0,1,0,1,1,1,1,0,0, then frame_done 1 cycle after the last result.
- All-ones kernel, same image -> first result 6 (top-left window); all 9 outputs match the reference model; busy drops with frame_done.
- Saturation width: all pixels 3, all coefs 3 -> every result 81, no overflow in 8-bit OW.
- Backpressure: toggle out_ready randomly at 50% -> out_data stable while stalled, in_ready=0 while out_valid & ~out_ready, no result lost or duplicated, 9 results total.
- Coefficient write during RUN (coef[4]=3) -> ignored, identity results unchanged; same write in IDLE -> next frame outputs tripled.
- rst_n asserted after 12 accepted pixels -> out_valid=0, busy=0 asynchronously; a new start runs a clean frame producing all-zero results (coefs reset).
